vip_stream_buffer: RTL and testbench

- Parametrised multi-channel valid/ready DUT used as the default target for generated UVM environments.
- Each channel accepts words through a valid/ready input port and buffers them in a private FIFO.
- Each word passes through a per-word transform selected by a mode input, then leaves through a valid/ready output port.
- Channels are fully independent; channel count, data width and FIFO depth are parameters.

---
 rtl/vip_stream_buffer.sv | 100 ++++++++++
 tb/tb_vip_stream_buffer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/vip_stream_buffer.sv
// Multi-channel valid/ready stream buffer: per-channel FIFO with a push-time word transform.
// Optional per-channel refused-input counters are enabled by defining VIP_STREAM_BUFFER_DROP_CNT_EN.
module vip_stream_buffer #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_CH-1:0]                  valid_i,
    output logic [NUM_CH-1:0]                  ready_o,
    input  logic [NUM_CH*DATA_W-1:0]           data_i,
    input  logic [2*NUM_CH-1:0]                mode_i,
    output logic [NUM_CH-1:0]                  out_valid_o,
    input  logic [NUM_CH-1:0]                  out_ready_i,
    output logic [NUM_CH*DATA_W-1:0]           data_o,
    output logic [NUM_CH*($clog2(DEPTH)+1)-1:0] level_o,
    output logic [NUM_CH*CNT_W-1:0]            drop_cnt_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    // Handshake: a word moves on a rising edge only when valid and ready are both high
    // on that edge; ready never depends on valid, and a full FIFO refuses even while popping.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [DATA_W-1:0] mem [DEPTH];
        logic [AW-1:0]     wr_ptr;
        logic [AW-1:0]     rd_ptr;
        logic [LW-1:0]     level;
        logic [DATA_W-1:0] din;
        logic [DATA_W-1:0] xform;
        logic [1:0]        mode;
        logic              push;
        logic              pop;

        assign din  = data_i[k*DATA_W +: DATA_W];
        assign mode = mode_i[2*k +: 2];

        always_comb begin
            xform = din;
            case (mode)
                2'b01:   xform = din + 1'b1;
                2'b10:   xform = ~din;
                2'b11: begin
                    for (int i = 0; i < DATA_W; i++) xform[i] = din[DATA_W-1-i];
                end
                default: xform = din;
            endcase
        end

        assign ready_o[k]     = (level != FULL_LEVEL);
        assign out_valid_o[k] = (level != '0);
        assign push           = valid_i[k] && ready_o[k];
        assign pop            = out_valid_o[k] && out_ready_i[k];

        // Storage needs no reset: the head is masked to zero whenever the channel is empty.
        always_ff @(posedge clk) begin
            if (push) mem[wr_ptr] <= xform;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   level <= level + 1'b1;
                    2'b01:   level <= level - 1'b1;
                    default: level <= level;
                endcase
            end
        end

        assign data_o[k*DATA_W +: DATA_W] = out_valid_o[k] ? mem[rd_ptr] : '0;
        assign level_o[k*LW +: LW]        = level;

`ifdef VIP_STREAM_BUFFER_DROP_CNT_EN
        logic [CNT_W-1:0] drop_cnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                drop_cnt <= '0;
            end else if (valid_i[k] && !ready_o[k] && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end

        assign drop_cnt_o[k*CNT_W +: CNT_W] = drop_cnt;
`else
        assign drop_cnt_o[k*CNT_W +: CNT_W] = '0;
`endif
    end

endmodule

// File: tb/tb_vip_stream_buffer.sv
// Directed self-checking bench for vip_stream_buffer (NUM_CH=2, DATA_W=8, DEPTH=4, CNT_W=16).
module tb_vip_stream_buffer;

    logic        clk;
    logic        rst_n;
    logic [1:0]  valid_i;
    logic [1:0]  ready_o;
    logic [15:0] data_i;
    logic [3:0]  mode_i;
    logic [1:0]  out_valid_o;
    logic [1:0]  out_ready_i;
    logic [15:0] data_o;
    logic [5:0]  level_o;
    logic [31:0] drop_cnt_o;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_w;

    vip_stream_buffer #(.NUM_CH(2), .DATA_W(8), .DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
        .data_i(data_i), .mode_i(mode_i), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .data_o(data_o), .level_o(level_o),
        .drop_cnt_o(drop_cnt_o)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int k, input logic v, input logic [7:0] d, input logic [1:0] m);
        valid_i[k]     = v;
        data_i[k*8 +: 8] = d;
        mode_i[2*k +: 2] = m;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (ready_o !== 2'b11) begin errors++; $display("FAIL reset_ready got %b exp 11", ready_o); end
        checks++; if (out_valid_o !== 2'b00) begin errors++; $display("FAIL reset_out_valid got %b exp 00", out_valid_o); end
        checks++; if (level_o !== 6'd0) begin errors++; $display("FAIL reset_level got %h exp 0", level_o); end
        checks++; if (data_o !== 16'h0) begin errors++; $display("FAIL reset_data got %h exp 0", data_o); end
        checks++; if (drop_cnt_o !== 32'h0) begin errors++; $display("FAIL reset_drop got %h exp 0", drop_cnt_o); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_pass_through();
        drive(0, 1'b1, 8'h11, 2'b00);
        tick();
        checks++; if (out_valid_o[0] !== 1'b1 || data_o[7:0] !== 8'h11) begin errors++; $display("FAIL pt_latency got v=%b d=%h exp v=1 d=11", out_valid_o[0], data_o[7:0]); end
        drive(0, 1'b1, 8'h22, 2'b00);
        tick();
        drive(0, 1'b1, 8'h33, 2'b00);
        tick();
        drive(0, 1'b0, 8'h00, 2'b00);
        checks++; if (level_o[2:0] !== 3'd3) begin errors++; $display("FAIL pt_level got %0d exp 3", level_o[2:0]); end
        checks++; if (level_o[5:3] !== 3'd0 || out_valid_o[1] !== 1'b0) begin errors++; $display("FAIL pt_ch1_idle got lvl=%0d v=%b exp 0 0", level_o[5:3], out_valid_o[1]); end
        exp_q = '{8'h11, 8'h22, 8'h33};
        out_ready_i[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_w = exp_q.pop_front();
            checks++; if (out_valid_o[0] !== 1'b1 || data_o[7:0] !== exp_w) begin errors++; $display("FAIL pt_pop%0d got v=%b d=%h exp %h", i, out_valid_o[0], data_o[7:0], exp_w); end
            tick();
        end
        out_ready_i[0] = 1'b0;
        checks++; if (out_valid_o[0] !== 1'b0 || data_o[7:0] !== 8'h00) begin errors++; $display("FAIL pt_empty got v=%b d=%h exp 0 00", out_valid_o[0], data_o[7:0]); end
        checks++; if (data_o[15:8] !== 8'h00 || out_valid_o[1] !== 1'b0) begin errors++; $display("FAIL pt_ch1_end got d=%h v=%b exp 00 0", data_o[15:8], out_valid_o[1]); end
    endtask

    task automatic test_modes();
        drive(1, 1'b1, 8'hFF, 2'b01); tick();
        drive(1, 1'b1, 8'h0F, 2'b10); tick();
        drive(1, 1'b1, 8'h01, 2'b11); tick();
        drive(1, 1'b0, 8'h00, 2'b00);
        checks++; if (level_o[5:3] !== 3'd3 || level_o[2:0] !== 3'd0) begin errors++; $display("FAIL modes_level got ch1=%0d ch0=%0d exp 3 0", level_o[5:3], level_o[2:0]); end
        exp_q = '{8'h00, 8'hF0, 8'h80};
        out_ready_i[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_w = exp_q.pop_front();
            checks++; if (out_valid_o[1] !== 1'b1 || data_o[15:8] !== exp_w) begin errors++; $display("FAIL modes_pop%0d got v=%b d=%h exp %h", i, out_valid_o[1], data_o[15:8], exp_w); end
            tick();
        end
        out_ready_i[1] = 1'b0;
    endtask

    task automatic test_mode_change();
        drive(1, 1'b1, 8'h05, 2'b01); tick();
        drive(1, 1'b0, 8'h00, 2'b10); tick();
        checks++; if (data_o[15:8] !== 8'h06) begin errors++; $display("FAIL modechg_data got %h exp 06", data_o[15:8]); end
        out_ready_i[1] = 1'b1; tick();
        out_ready_i[1] = 1'b0;
        checks++; if (out_valid_o[1] !== 1'b0) begin errors++; $display("FAIL modechg_empty got %b exp 0", out_valid_o[1]); end
        mode_i[3:2] = 2'b00;
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) begin
            drive(0, 1'b1, 8'hA0 + 8'(i), 2'b00);
            tick();
        end
        checks++; if (ready_o[0] !== 1'b0 || level_o[2:0] !== 3'd4) begin errors++; $display("FAIL full_reach got r=%b lvl=%0d exp 0 4", ready_o[0], level_o[2:0]); end
        drive(0, 1'b1, 8'hEE, 2'b00);
        for (int i = 0; i < 3; i++) tick();
        checks++; if (ready_o[0] !== 1'b0 || level_o[2:0] !== 3'd4 || data_o[7:0] !== 8'hA0) begin errors++; $display("FAIL full_hold got r=%b lvl=%0d d=%h exp 0 4 a0", ready_o[0], level_o[2:0], data_o[7:0]); end
`ifdef VIP_STREAM_BUFFER_DROP_CNT_EN
        checks++; if (drop_cnt_o[15:0] !== 16'd3) begin errors++; $display("FAIL full_drop got %0d exp 3", drop_cnt_o[15:0]); end
`else
        checks++; if (drop_cnt_o[15:0] !== 16'd0) begin errors++; $display("FAIL full_drop got %0d exp 0", drop_cnt_o[15:0]); end
`endif
        // Pop while still offering a word: full refuses it, level drops to 3.
        out_ready_i[0] = 1'b1; tick();
        out_ready_i[0] = 1'b0;
        drive(0, 1'b0, 8'h00, 2'b00);
        checks++; if (ready_o[0] !== 1'b1 || level_o[2:0] !== 3'd3 || data_o[7:0] !== 8'hA1) begin errors++; $display("FAIL full_pop got r=%b lvl=%0d d=%h exp 1 3 a1", ready_o[0], level_o[2:0], data_o[7:0]); end
`ifdef VIP_STREAM_BUFFER_DROP_CNT_EN
        checks++; if (drop_cnt_o !== 32'd4) begin errors++; $display("FAIL full_drop2 got %h exp 4", drop_cnt_o); end
`else
        checks++; if (drop_cnt_o !== 32'd0) begin errors++; $display("FAIL full_drop2 got %h exp 0", drop_cnt_o); end
`endif
        exp_q = '{8'hA1, 8'hA2, 8'hA3};
        out_ready_i[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_w = exp_q.pop_front();
            checks++; if (data_o[7:0] !== exp_w) begin errors++; $display("FAIL full_drain%0d got %h exp %h", i, data_o[7:0], exp_w); end
            tick();
        end
        out_ready_i[0] = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_q = '{8'h40, 8'h41};
        drive(0, 1'b1, 8'h40, 2'b00); tick();
        drive(0, 1'b1, 8'h41, 2'b00); tick();
        out_ready_i[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(0, 1'b1, 8'h42 + 8'(i), 2'b00);
            exp_w = exp_q.pop_front();
            exp_q.push_back(8'h42 + 8'(i));
            checks++; if (data_o[7:0] !== exp_w) begin errors++; $display("FAIL b2b_data%0d got %h exp %h", i, data_o[7:0], exp_w); end
            tick();
            checks++; if (level_o[2:0] !== 3'd2) begin errors++; $display("FAIL b2b_level%0d got %0d exp 2", i, level_o[2:0]); end
        end
        drive(0, 1'b0, 8'h00, 2'b00);
        for (int i = 0; i < 2; i++) begin
            exp_w = exp_q.pop_front();
            checks++; if (data_o[7:0] !== exp_w) begin errors++; $display("FAIL b2b_drain%0d got %h exp %h", i, data_o[7:0], exp_w); end
            tick();
        end
        out_ready_i[0] = 1'b0;
        checks++; if (level_o !== 6'd0) begin errors++; $display("FAIL b2b_end got %h exp 0", level_o); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1'b1, 8'h10 + 8'(i), 2'b00);
            drive(1, 1'b1, 8'h20 + 8'(i), 2'b00);
            tick();
        end
        drive(0, 1'b0, 8'h00, 2'b00);
        drive(1, 1'b0, 8'h00, 2'b00);
        checks++; if (level_o !== {3'd3, 3'd3}) begin errors++; $display("FAIL rstmid_pre got %h exp 1b", level_o); end
        rst_n = 1'b0;
        #2;
        checks++; if (ready_o !== 2'b11 || out_valid_o !== 2'b00) begin errors++; $display("FAIL rstmid_hs got r=%b v=%b exp 11 00", ready_o, out_valid_o); end
        checks++; if (level_o !== 6'd0 || data_o !== 16'h0 || drop_cnt_o !== 32'h0) begin errors++; $display("FAIL rstmid_state got l=%h d=%h c=%h exp 0", level_o, data_o, drop_cnt_o); end
        #2;
        rst_n = 1'b1;
        drive(0, 1'b1, 8'hAA, 2'b00);
        tick();
        drive(0, 1'b0, 8'h00, 2'b00);
        checks++; if (data_o[7:0] !== 8'hAA || level_o[2:0] !== 3'd1) begin errors++; $display("FAIL rstmid_first got d=%h lvl=%0d exp aa 1", data_o[7:0], level_o[2:0]); end
    endtask

    initial begin
        rst_n       = 1'b0;
        valid_i     = '0;
        data_i      = '0;
        mode_i      = '0;
        out_ready_i = '0;
        test_reset();
        test_pass_through();
        test_modes();
        test_mode_change();
        test_full();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
